instr_mem_loader: RTL and testbench

INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

---
 rtl/instr_mem_loader.sv | 107 ++++++++++
 tb/tb_instr_mem_loader.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader.sv
// Serial program loader: assembles a big-endian byte stream into 32-bit words,
// writes them to instruction memory and holds the CPU until a halt word or a full memory.
module instr_mem_loader #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              loadStart,
  input  logic              byteValid,
  input  logic [7:0]        byteData,
  output logic              byteReady,
  output logic              wrEn,
  output logic [ADDR_W-1:0] wrAddr,
  output logic [31:0]       wrData,
  output logic              cpuHold,
  output logic              loadDone,
  output logic [ADDR_W:0]   wordCount,
  output logic              overflow
);

  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

  localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] COUNT_ONE = (ADDR_W+1)'(1);

  state_t          state, state_nx;
  logic [31:0]     word_q, word_nx;
  logic [1:0]      byte_idx, byte_idx_nx;
  logic [ADDR_W:0] count_q, count_nx;
  logic            ovf_q, ovf_nx;
  logic            is_halt;

  // LC2K halt opcode sits in bits 24:22 of the instruction word.
  assign is_halt = (word_q[24:22] == 3'b110);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      word_q   <= '0;
      byte_idx <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state    <= state_nx;
      word_q   <= word_nx;
      byte_idx <= byte_idx_nx;
      count_q  <= count_nx;
      ovf_q    <= ovf_nx;
    end
  end

  // NOTE: every signal gets its hold value first so no path through the
  // case statement leaves one unassigned, which would infer a latch.
  always_comb begin
    state_nx    = state;
    word_nx     = word_q;
    byte_idx_nx = byte_idx;
    count_nx    = count_q;
    ovf_nx      = ovf_q;

    unique case (state)
      IDLE, DONE: begin
        if (loadStart) begin
          state_nx    = RECV;
          word_nx     = '0;
          byte_idx_nx = '0;
          count_nx    = '0;
          ovf_nx      = 1'b0;
        end
      end
      RECV: begin
        if (byteValid) begin
          word_nx     = {word_q[23:0], byteData};
          byte_idx_nx = byte_idx + 2'd1;
          if (byte_idx == 2'd3) state_nx = WRITE;
        end
      end
      WRITE: begin
        count_nx    = count_q + COUNT_ONE;
        byte_idx_nx = '0;
        if (is_halt) begin
          state_nx = DONE;
        end else if (count_q == LAST_ADDR) begin
          state_nx = DONE;
          ovf_nx   = 1'b1;
        end else begin
          state_nx = RECV;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Outputs decode directly from registered state, so they carry no X after reset.
  assign byteReady = (state == RECV);
  assign wrEn      = (state == WRITE);
  assign cpuHold   = (state == RECV) || (state == WRITE);
  assign loadDone  = (state == DONE);
  assign wrAddr    = count_q[ADDR_W-1:0];
  assign wrData    = word_q;
  assign wordCount = count_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench: a default-size loader and a DEPTH=4 loader share one stimulus stream;
// expected writes are queued by the driver and popped by a monitor on every wrEn.
module tb_instr_mem_loader;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, loadStart, byteValid;
  logic [7:0]  byteData;

  logic        r64, we64, hold64, done64, ov64;
  logic [5:0]  wa64;
  logic [31:0] wd64;
  logic [6:0]  wc64;

  logic        r4, we4, hold4, done4, ov4;
  logic [1:0]  wa4;
  logic [31:0] wd4;
  logic [2:0]  wc4;

  exp_t q64[$];
  exp_t q4[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   last_acc = 0;
  int   hold_lost = 0;
  logic hold_watch = 1'b0;

  instr_mem_loader dut64 (
    .clk(clk), .reset(reset), .loadStart(loadStart), .byteValid(byteValid),
    .byteData(byteData), .byteReady(r64), .wrEn(we64), .wrAddr(wa64), .wrData(wd64),
    .cpuHold(hold64), .loadDone(done64), .wordCount(wc64), .overflow(ov64)
  );

  instr_mem_loader #(.DEPTH(4), .ADDR_W(2)) dut4 (
    .clk(clk), .reset(reset), .loadStart(loadStart), .byteValid(byteValid),
    .byteData(byteData), .byteReady(r4), .wrEn(we4), .wrAddr(wa4), .wrData(wd4),
    .cpuHold(hold4), .loadDone(done4), .wordCount(wc4), .overflow(ov4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops an expectation on every write, including the cycle it must occur in.
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (hold_watch && !hold64) hold_lost++;
    if (we64 === 1'b1) begin
      if (q64.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL unexpected_write64: addr %h data %h expected no write", wa64, wd64);
      end else begin
        e = q64.pop_front();
        check("wr_addr64", 32'(wa64), e.addr);
        check("wr_data64", wd64, e.data);
        check("wr_cycle64", 32'(cyc), 32'(e.cyc));
      end
    end
    if (we4 === 1'b1) begin
      if (q4.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL unexpected_write4: addr %h data %h expected no write", wa4, wd4);
      end else begin
        e = q4.pop_front();
        check("wr_addr4", 32'(wa4), e.addr);
        check("wr_data4", wd4, e.data);
        check("wr_cycle4", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ready64"}, 32'(r64), 0);   check({tag, "_ready4"}, 32'(r4), 0);
    check({tag, "_wren64"}, 32'(we64), 0);   check({tag, "_wren4"}, 32'(we4), 0);
    check({tag, "_addr64"}, 32'(wa64), 0);   check({tag, "_addr4"}, 32'(wa4), 0);
    check({tag, "_data64"}, wd64, 0);        check({tag, "_data4"}, wd4, 0);
    check({tag, "_hold64"}, 32'(hold64), 0); check({tag, "_hold4"}, 32'(hold4), 0);
    check({tag, "_done64"}, 32'(done64), 0); check({tag, "_done4"}, 32'(done4), 0);
    check({tag, "_count64"}, 32'(wc64), 0);  check({tag, "_count4"}, 32'(wc4), 0);
    check({tag, "_ovf64"}, 32'(ov64), 0);    check({tag, "_ovf4"}, 32'(ov4), 0);
  endtask

  // Reset optionally collides with loadStart and byteValid; reset must win.
  task automatic do_reset(input string tag, input logic collide);
    reset = 1'b1; loadStart = collide; byteValid = collide; byteData = 8'h5A;
    repeat (2) tick();
    check_reset_state(tag);
    reset = 1'b0; loadStart = 1'b0; byteValid = 1'b0;
  endtask

  task automatic pulse_start();
    loadStart = 1'b1;
    tick();
    loadStart = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    byteValid = 1'b0;
    repeat (gap) tick();
    byteValid = 1'b1;
    byteData  = b;
    while (r64 !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) begin
      n_checks++; n_errors++;
      $display("FAIL byte_timeout: byteReady %b expected 1 within 20 cycles", r64);
    end
    tick();
    last_acc  = cyc;
    byteValid = 1'b0;
  endtask

  task automatic push_exp(input logic [31:0] addr, input logic [31:0] data, input logic to4);
    exp_t e;
    e.addr = addr; e.data = data; e.cyc = last_acc;
    q64.push_back(e);
    if (to4) q4.push_back(e);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap, input logic [31:0] addr,
                           input logic to4);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8], gap);
    push_exp(addr, w, to4);
  endtask

  initial begin
    reset = 1'b1; loadStart = 1'b0; byteValid = 1'b0; byteData = 8'h00;
    do_reset("rst0", 1'b0);

    // Bytes offered in IDLE must be ignored, then a two-word program ending in halt.
    byteValid = 1'b1; byteData = 8'hFF;
    repeat (3) tick();
    check("idle_ready64", 32'(r64), 0);
    byteValid = 1'b0;
    pulse_start();
    check("recv_hold64", 32'(hold64), 1);
    check("recv_ready64", 32'(r64), 1);
    send_word(32'h0081000A, 0, 0, 1'b1);
    send_word(32'h01800000, 0, 1, 1'b1);
    tick();
    check("halt_done64", 32'(done64), 1);  check("halt_hold64", 32'(hold64), 0);
    check("halt_count64", 32'(wc64), 2);   check("halt_ovf64", 32'(ov64), 0);
    check("halt_done4", 32'(done4), 1);    check("halt_count4", 32'(wc4), 2);

    // Reload from DONE clears loadDone and wordCount on the next cycle.
    pulse_start();
    check("reload_done64", 32'(done64), 0);
    check("reload_count64", 32'(wc64), 0);
    check("reload_ovf64", 32'(ov64), 0);

    // Sparse byte stream: one write, one cycle after the 4th byte, CPU held throughout.
    hold_watch = 1'b1;
    send_word(32'h004A0001, 2, 0, 1'b1);
    hold_watch = 1'b0;
    check("gap_hold_lost", 32'(hold_lost), 0);
    tick();

    // loadStart mid-word is ignored: the partial word survives and wordCount stays 1.
    send_byte(8'h01, 0);
    send_byte(8'h80, 0);
    pulse_start();
    check("midload_count64", 32'(wc64), 1);
    check("midload_ready64", 32'(r64), 1);
    send_byte(8'hFF, 0);
    send_byte(8'hFF, 0);
    push_exp(1, 32'h0180FFFF, 1'b1);
    tick();
    check("second_done64", 32'(done64), 1);
    check("second_count64", 32'(wc64), 2);

    // Four non-halt words: DEPTH=4 instance overflows, default instance keeps going.
    pulse_start();
    send_word(32'h11111111, 0, 0, 1'b1);
    send_word(32'h22222222, 0, 1, 1'b1);
    send_word(32'h00000003, 0, 2, 1'b1);
    send_word(32'h7FFFFFFF, 0, 3, 1'b1);
    tick();
    check("ovf_flag4", 32'(ov4), 1);       check("ovf_count4", 32'(wc4), 4);
    check("ovf_done4", 32'(done4), 1);     check("ovf_hold4", 32'(hold4), 0);
    check("ovf_flag64", 32'(ov64), 0);     check("ovf_count64", 32'(wc64), 4);
    check("ovf_hold64", 32'(hold64), 1);
    send_word(32'h00000005, 0, 4, 1'b0);
    tick();
    check("post_ovf_ready4", 32'(r4), 0);
    check("post_ovf_count4", 32'(wc4), 4);
    check("post_ovf_flag4", 32'(ov4), 1);

    // Reset after two bytes of a word discards them; reload writes from address 0.
    do_reset("rst1", 1'b0);
    pulse_start();
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    do_reset("rst2", 1'b1);
    pulse_start();
    send_word(32'hAB800001, 0, 0, 1'b1);
    tick();
    check("final_done64", 32'(done64), 1);
    check("final_count64", 32'(wc64), 1);
    check("final_done4", 32'(done4), 1);

    repeat (3) tick();
    check("queue64_empty", 32'(q64.size()), 0);
    check("queue4_empty", 32'(q4.size()), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
